vga_sync_gen: RTL and testbench

Parametrised VGA timing generator and sync conditioner. It counts pixels and lines for a configurable video mode and produces hsync and vsync with per-signal polarity, a data-enable, pixel coordinates, and line/frame strobes. An optional output delay line aligns the sync signals with a downstream pixel pipeline of known latency. It sits between the pixel-clock domain logic and the VGA pins, and replaces a fixed-function polarity stage.

---
 rtl/vga_timing_pkg.sv | 56 +++++
 rtl/sync_delay_line.sv | 43 ++++
 rtl/vga_sync_gen.sv | 147 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the VGA timing generator:
//   - default 640x480@60 mode constants and the total-period derivation
//   - clog2 helper used for elaboration-time range checks
//   - vga_out_t, the packed bundle carried through the output pipeline,
//     plus idle_out(), which builds the reset/idle value of that bundle
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Widest coordinate the bundle can carry; the top narrows to XW/YW.
  localparam int COORD_W = 16;

  function automatic int mode_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = mode_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = mode_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  // Smallest n with 2**n >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int n;
    n = 0;
    while ((1 << n) < value) n++;
    return n;
  endfunction

  typedef struct packed {
    logic               hsync;
    logic               vsync;
    logic               de;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               line_start;
    logic               frame_start;
  } vga_out_t;

  // Idle bundle: syncs at their deasserted level, everything else low.
  function automatic vga_out_t idle_out(input logic hpol, input logic vpol);
    vga_out_t o;
    o       = '0;
    o.hsync = ~hpol;
    o.vsync = ~vpol;
    return o;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line
// WIDTH x DEPTH shift register that advances only when en is high.
// reset loads every stage with rst_val. DEPTH=0 degenerates to a wire.
// Ports:
//   clk      clock
//   reset    synchronous active-high reset (priority over en)
//   en       shift enable
//   rst_val  value loaded into all stages on reset
//   d        input word
//   q        output word, DEPTH en-cycles behind d
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    // Pass-through: the control inputs have no effect in this configuration.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, en, rst_val};
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stages[i] <= rst_val;
      end else if (en) begin
        stages[0] <= d;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign q = stages[DEPTH-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Parametrised VGA timing generator. Free-running pixel/line counters are
// decoded into sync, data-enable, coordinates and line/frame strobes; the
// decode is registered once (stage 0) and then passed through an optional
// DELAY-deep enabled delay line so the syncs can line up with a downstream
// pixel pipeline. All state advances only on en=1 cycles.
// Ports:
//   clk          pixel-domain clock
//   reset        synchronous active-high reset (priority over en)
//   en           pixel clock enable
//   hsync/vsync  syncs at HPOL/VPOL level while asserted
//   de           active-region flag
//   x, y         pixel coordinates while de=1, else 0
//   line_start   one-en-cycle pulse at h=0 of every line
//   frame_start  one-en-cycle pulse at h=0, v=0
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HPOL     = 1'b0,
  parameter bit VPOL     = 1'b0,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int DELAY    = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = mode_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = mode_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_sync_gen: every timing parameter must be non-zero");
  end
  if (clog2(H_TOTAL) > XW) begin : g_bad_xw
    $error("vga_sync_gen: XW too narrow for H_TOTAL");
  end
  if (clog2(V_TOTAL) > YW) begin : g_bad_yw
    $error("vga_sync_gen: YW too narrow for V_TOTAL");
  end
  if (XW > COORD_W || YW > COORD_W || XW < 1 || YW < 1) begin : g_bad_coord
    $error("vga_sync_gen: XW/YW outside the supported coordinate width");
  end
  if (DELAY < 0 || DELAY > 15) begin : g_bad_delay
    $error("vga_sync_gen: DELAY must be 0..15");
  end

  // Decode boundaries at counter width. The sync end values are at most
  // TOTAL-BP, so they always fit because BP is at least 1.
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_X  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_Y  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  localparam vga_out_t IDLE = idle_out(HPOL, VPOL);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  vga_out_t      dec;
  vga_out_t      stage0;
  vga_out_t      pins;

  // Position counters: h wraps every H_TOTAL en cycles, v steps on h wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Combinational decode of the current position. vsync depends only on
  // v_cnt, so its edges fall on h=0 automatically.
  always_comb begin
    dec             = IDLE;
    dec.de          = (h_cnt < H_ACT_X) && (v_cnt < V_ACT_Y);
    dec.hsync       = (h_cnt >= HS_START && h_cnt < HS_END) ? HPOL : ~HPOL;
    dec.vsync       = (v_cnt >= VS_START && v_cnt < VS_END) ? VPOL : ~VPOL;
    dec.x           = dec.de ? COORD_W'(h_cnt) : '0;
    dec.y           = dec.de ? COORD_W'(v_cnt) : '0;
    dec.line_start  = (h_cnt == '0);
    dec.frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

  // Stage 0 captures the decode in the same en cycle the counters advance.
  // Holding on en=0 keeps strobes high until the next en=1 cycle consumes
  // them, so they never re-fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage0 <= IDLE;
    end else if (en) begin
      stage0 <= dec;
    end
  end

  sync_delay_line #(
    .WIDTH($bits(vga_out_t)),
    .DEPTH(DELAY)
  ) u_delay (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .rst_val(IDLE),
    .d      (stage0),
    .q      (pins)
  );

  assign hsync       = pins.hsync;
  assign vsync       = pins.vsync;
  assign de          = pins.de;
  assign x           = pins.x[XW-1:0];
  assign y           = pins.y[YW-1:0];
  assign line_start  = pins.line_start;
  assign frame_start = pins.frame_start;

  // Coordinate bits above XW/YW are always zero.
  logic unused_coord_hi;
  assign unused_coord_hi = ^{pins.x, pins.y};

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen
// Four generator instances run side by side, each against a position model:
//   A  default 640x480 mode, en=1, DELAY=0
//   B  small mode (H 4/1/2/1, V 3/1/1/1), XW=YW=3, mid-frame reset with en=0
//   C  small mode, HPOL=VPOL=1, DELAY=3, en toggling with a pause and a reset
//   D  default horizontal, short vertical (6/2/2/2), HPOL=VPOL=1, reset at (700,3)
// The model: after n accepted en cycles since reset, the pins show the decode
// of raster position k = n-1-DELAY (idle when k<0), with h = k mod H_TOTAL and
// v = (k div H_TOTAL) mod V_TOTAL.
module tb_vga_sync_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } mode_t;

  typedef struct {
    bit hs, vs, de;
    int x, y;
    bit ls, fs;
  } exp_t;

  mode_t m_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  mode_t m_b = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0};
  mode_t m_c = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
  mode_t m_d = '{640, 16, 96, 48, 6, 2, 2, 2, 1'b1, 1'b1};

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, rst_d;
  logic en_a, en_b, en_c, en_d;

  // ---------------- DUTs ----------------
  logic a_hs, a_vs, a_de, a_ls, a_fs; logic [9:0] a_x; logic [9:0] a_y;
  logic b_hs, b_vs, b_de, b_ls, b_fs; logic [2:0] b_x; logic [2:0] b_y;
  logic c_hs, c_vs, c_de, c_ls, c_fs; logic [2:0] c_x; logic [2:0] c_y;
  logic d_hs, d_vs, d_de, d_ls, d_fs; logic [9:0] d_x; logic [3:0] d_y;

  vga_sync_gen u_a (
    .clk(clk), .reset(rst_a), .en(en_a), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .XW(3), .YW(3)
  ) u_b (
    .clk(clk), .reset(rst_b), .en(en_b), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HPOL(1'b1), .VPOL(1'b1), .XW(3), .YW(3), .DELAY(3)
  ) u_c (
    .clk(clk), .reset(rst_c), .en(en_c), .hsync(c_hs), .vsync(c_vs), .de(c_de),
    .x(c_x), .y(c_y), .line_start(c_ls), .frame_start(c_fs)
  );

  vga_sync_gen #(
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HPOL(1'b1), .VPOL(1'b1), .XW(10), .YW(4)
  ) u_d (
    .clk(clk), .reset(rst_d), .en(en_d), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
  );

  // ---------------- model ----------------
  function automatic exp_t model(input mode_t m, input int k);
    exp_t e;
    int ht, vt, h, v;
    ht   = m.ha + m.hf + m.hs + m.hb;
    vt   = m.va + m.vf + m.vs + m.vb;
    e.hs = ~m.hp; e.vs = ~m.vp; e.de = 1'b0;
    e.x  = 0;     e.y  = 0;     e.ls = 1'b0; e.fs = 1'b0;
    if (k >= 0) begin
      h    = k % ht;
      v    = (k / ht) % vt;
      e.de = (h < m.ha) && (v < m.va);
      if (h >= m.ha + m.hf && h < m.ha + m.hf + m.hs) e.hs = m.hp;
      if (v >= m.va + m.vf && v < m.va + m.vf + m.vs) e.vs = m.vp;
      if (e.de) begin
        e.x = h;
        e.y = v;
      end
      e.ls = (h == 0);
      e.fs = (h == 0) && (v == 0);
    end
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_one(input string nm, input int k, input exp_t e,
                           input logic hs, input logic vs, input logic de,
                           input logic [15:0] x, input logic [15:0] y,
                           input logic ls, input logic fs);
    checks++;
    if (hs !== e.hs || vs !== e.vs || de !== e.de || ls !== e.ls || fs !== e.fs ||
        x !== 16'(e.x) || y !== 16'(e.y)) begin
      failures++;
      $display("FAIL %s k=%0d got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b required hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
               nm, k, hs, vs, de, x, y, ls, fs, e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs);
    end
  endtask

  task automatic check_lit(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", nm, got, want);
    end
  endtask

  // Accepted-en counters since each instance's last reset.
  int n_a = 0, n_b = 0, n_c = 0, n_d = 0;
  always @(posedge clk) begin
    if (rst_a) n_a <= 0; else if (en_a) n_a <= n_a + 1;
    if (rst_b) n_b <= 0; else if (en_b) n_b <= n_b + 1;
    if (rst_c) n_c <= 0; else if (en_c) n_c <= n_c + 1;
    if (rst_d) n_d <= 0; else if (en_d) n_d <= n_d + 1;
  end

  bit chk_on = 1'b0;
  bit b_post = 1'b0;
  bit d_post = 1'b0;
  bit d_first = 1'b0;

  int a_de_cnt = 0, a_hs_low = 0, a_ls_cnt = 0, a_fs_cnt = 0;
  int d_hs_hi = 0, d_vs_hi = 0, d_de_cnt = 0, d_ls_cnt = 0, d_fs_cnt = 0;
  int b_fs_seen = 0;
  int b_fs_n [2];

  // Compare process: every cycle, every instance, on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check_one("a", n_a - 1, model(m_a, n_a - 1), a_hs, a_vs, a_de, 16'(a_x), 16'(a_y), a_ls, a_fs);
      check_one("b", n_b - 1, model(m_b, n_b - 1), b_hs, b_vs, b_de, 16'(b_x), 16'(b_y), b_ls, b_fs);
      check_one("c", n_c - 4, model(m_c, n_c - 4), c_hs, c_vs, c_de, 16'(c_x), 16'(c_y), c_ls, c_fs);
      check_one("d", n_d - 1, model(m_d, n_d - 1), d_hs, d_vs, d_de, 16'(d_x), 16'(d_y), d_ls, d_fs);

      if (n_a >= 1 && n_a <= 1600) begin
        a_de_cnt += int'(a_de);
        a_hs_low += int'(!a_hs);
        a_ls_cnt += int'(a_ls);
        a_fs_cnt += int'(a_fs);
      end
      if (!d_post && n_d >= 1 && n_d <= 800) d_hs_hi += int'(d_hs);
      if (d_post && n_d >= 1 && n_d <= 9600) begin
        d_vs_hi  += int'(d_vs);
        d_de_cnt += int'(d_de);
        d_ls_cnt += int'(d_ls);
        d_fs_cnt += int'(d_fs);
      end
      if (b_post && b_fs === 1'b1 && b_fs_seen < 2) begin
        b_fs_n[b_fs_seen] = n_b;
        b_fs_seen++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    exp_t t;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    en_a  = 1'b0; en_b  = 1'b0; en_c  = 1'b0; en_d  = 1'b0;
    @(posedge clk); #1;
    chk_on = 1'b1;

    // Hand-computed pins on the model itself.
    t = model(m_a, 655); check_lit("model_a_hs_655", int'(t.hs), 1);
    t = model(m_a, 656); check_lit("model_a_hs_656", int'(t.hs), 0);
    t = model(m_a, 751); check_lit("model_a_hs_751", int'(t.hs), 0);
    t = model(m_a, 752); check_lit("model_a_hs_752", int'(t.hs), 1);
    t = model(m_a, 639); check_lit("model_a_x_639", t.x, 639);
    t = model(m_a, 640); check_lit("model_a_de_640", int'(t.de), 0);
    t = model(m_a, 800); check_lit("model_a_y_800", t.y, 1);
    t = model(m_b, 5);   check_lit("model_b_hs_5", int'(t.hs), 0);
    t = model(m_b, 7);   check_lit("model_b_hs_7", int'(t.hs), 1);
    t = model(m_b, 31);  check_lit("model_b_vs_31", int'(t.vs), 1);
    t = model(m_b, 32);  check_lit("model_b_vs_32", int'(t.vs), 0);
    t = model(m_b, 48);  check_lit("model_b_fs_48", int'(t.fs), 1);

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1; en_d  = 1'b1;

    for (int c = 0; c < 13000; c++) begin
      @(posedge clk); #1;

      // B: reset mid-frame while en is low (reset wins).
      if (c == 100) begin
        rst_b = 1'b1; en_b = 1'b0;
      end else if (c == 101) begin
        rst_b = 1'b0; en_b = 1'b1; b_post = 1'b1;
      end

      // C: en toggles 1,0,1,0 with a short pause, reset lands on an en=0 cycle.
      en_c  = (c % 2 == 0) && !(c >= 200 && c < 206);
      rst_c = (c == 401);

      // D: reset when the counters sit at h=700, v=3, then check release.
      if (d_first) begin
        d_first = 1'b0;
        check_lit("d_rel_de", int'(d_de), 1);
        check_lit("d_rel_fs", int'(d_fs), 1);
        check_lit("d_rel_ls", int'(d_ls), 1);
        check_lit("d_rel_x",  int'(d_x), 0);
        check_lit("d_rel_y",  int'(d_y), 0);
      end else if (rst_d) begin
        rst_d = 1'b0; d_post = 1'b1; d_first = 1'b1;
        check_lit("d_rst_de", int'(d_de), 0);
        check_lit("d_rst_hs", int'(d_hs), 0);
        check_lit("d_rst_vs", int'(d_vs), 0);
        check_lit("d_rst_x",  int'(d_x), 0);
        check_lit("d_rst_fs", int'(d_fs), 0);
      end else if (!d_post && n_d == 3100) begin
        rst_d = 1'b1;
      end
    end

    @(negedge clk); #1;
    check_lit("a_de_2lines",    a_de_cnt, 1280);
    check_lit("a_hs_low_2lines", a_hs_low, 192);
    check_lit("a_ls_2lines",    a_ls_cnt, 2);
    check_lit("a_fs_2lines",    a_fs_cnt, 1);
    check_lit("d_hs_hi_line",   d_hs_hi, 96);
    check_lit("d_vs_hi_frame",  d_vs_hi, 1600);
    check_lit("d_de_frame",     d_de_cnt, 3840);
    check_lit("d_ls_frame",     d_ls_cnt, 12);
    check_lit("d_fs_frame",     d_fs_cnt, 1);
    check_lit("b_fs_seen",      b_fs_seen, 2);
    check_lit("b_fs_period",    b_fs_n[1] - b_fs_n[0], 48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
